ex_mem_pipe_stage: RTL

- Parametrised, elastic successor to the execute-to-memory pipeline register of the pipelined MIPS core.
- Carries the E-stage control and data fields (RegWrite, MemtoReg, MemWrite, ALU result, store data, destination register) to the M stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a multi-cycle data memory can stall M without a combinational ready path back into E.
- Adds synchronous flush (bubble insertion) and configurable field widths.

---
 rtl/ex_mem_pipe_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX->MEM pipeline register. A 2-entry skid buffer keeps in_ready registered.
// Optional stall counter: define EX_MEM_STALL_CNT_EN to add the stall_cycles output.
module ex_mem_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic [DATA_W-1:0] ALUInE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_W-1:0]  WriteRegE,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              MemWriteM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [REG_W-1:0]  WriteRegM,
   output logic [1:0]        occupancy
`ifdef EX_MEM_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] wdata;
      logic [REG_W-1:0]  wreg;
   } entry_t;

   entry_t in_ent;
   entry_t h_q, h_d;
   entry_t s_q, s_d;
   logic   h_v_q, h_v_d;
   logic   s_v_q, s_v_d;
   logic   in_fire;
   logic   out_fire;
   logic   h_free;

   always_comb begin
      in_ent.reg_write  = RegWriteE;
      in_ent.mem_to_reg = MemtoRegE;
      in_ent.mem_write  = MemWriteE;
      in_ent.alu        = ALUInE;
      in_ent.wdata      = WriteDataE;
      in_ent.wreg       = WriteRegE;
   end

   assign in_ready = ~s_v_q;
   assign out_valid = h_v_q;
   assign in_fire  = in_valid & ~s_v_q;
   assign out_fire = h_v_q & out_ready;
   assign h_free   = ~h_v_q | out_fire;

   always_comb begin
      h_d   = h_q;
      s_d   = s_q;
      h_v_d = h_v_q;
      s_v_d = s_v_q;
      if (flush) begin
         // Data fields are left alone; only the valid bits are dropped.
         h_v_d = 1'b0;
         s_v_d = 1'b0;
      end else if (h_free) begin
         if (s_v_q) begin
            h_d   = s_q;
            h_v_d = 1'b1;
            s_v_d = 1'b0;
            if (in_fire) begin
               s_d   = in_ent;
               s_v_d = 1'b1;
            end
         end else if (in_fire) begin
            h_d   = in_ent;
            h_v_d = 1'b1;
         end else begin
            h_v_d = 1'b0;
         end
      end else if (in_fire) begin
         s_d   = in_ent;
         s_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q   <= '0;
         s_q   <= '0;
         h_v_q <= 1'b0;
         s_v_q <= 1'b0;
      end else begin
         h_q   <= h_d;
         s_q   <= s_d;
         h_v_q <= h_v_d;
         s_v_q <= s_v_d;
      end
   end

   // Control bits are masked so a bubble can never write the register file or memory.
   assign RegWriteM  = h_q.reg_write  & h_v_q;
   assign MemtoRegM  = h_q.mem_to_reg & h_v_q;
   assign MemWriteM  = h_q.mem_write  & h_v_q;
   assign ALUOutM    = h_q.alu;
   assign WriteDataM = h_q.wdata;
   assign WriteRegM  = h_q.wreg;
   assign occupancy  = {1'b0, h_v_q} + {1'b0, s_v_q};

`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (h_v_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule
